rca_grid_lsq: RTL and testbench

- Responder end of the grid-to-LSQ channel (lsq modport of rca_lsq_grid_interface) and initiator of the LSQ-to-LSU channel (lsq modport of rca_lsu_interface).
- Captures up to GRID_NUM_ROWS load/store requests per cycle from the reconfigurable grid rows and queues them in row order.
- Issues queued requests one at a time to the shared LSU, and holds rca_lsu_lock so normal pipeline issue is kept off the LSU while the RCA owns it.

---
 rtl/rca_config.sv | 20 ++
 rtl/rca_multi_push_fifo.sv | 73 +++++++
 rtl/rca_grid_lsq.sv | 107 ++++++++++
 tb/tb_rca_grid_lsq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rca_config.sv
// Shared types and constants for the RCA grid-to-LSU load/store queue.
package rca_config;

    localparam int GRID_NUM_ROWS = 4;
    localparam int RCA_XLEN      = 32;

    typedef struct packed {
        logic [RCA_XLEN-1:0] addr;
        logic [RCA_XLEN-1:0] data;
        logic [2:0]          fn3;
        logic                is_store;
    } rca_lsq_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } rca_lsq_state_t;

endpackage

// File: rtl/rca_multi_push_fifo.sv
// Multi-write, single-read circular queue; set push bits are stored in ascending index order.
module rca_multi_push_fifo
    import rca_config::*;
#(
    parameter  int DEPTH    = 8,
    parameter  int NUM_PUSH = 4,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PUSH-1:0] push,
    input  rca_lsq_entry_t      entries [NUM_PUSH],
    input  logic                pop,
    output rca_lsq_entry_t      head,
    output logic [CW-1:0]       count,
    output logic [CW-1:0]       count_next
);

    rca_lsq_entry_t      mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       free_slots;
    logic [CW-1:0]       accepted;
    logic [NUM_PUSH-1:0] wr_en;
    logic [PW-1:0]       wr_idx [NUM_PUSH];
    logic [PW-1:0]       head_idx;
    logic                pop_ok;

    assign free_slots = CW'(DEPTH) - count_q;
    assign pop_ok     = pop && (count_q != '0);

    // Rows that would not fit are dropped; a popped slot is only reusable next cycle.
    always_comb begin
        accepted = '0;
        for (int i = 0; i < NUM_PUSH; i++) begin
            wr_en[i]  = 1'b0;
            wr_idx[i] = wr_ptr_q + accepted[PW-1:0];
            if (push[i] && (accepted < free_slots)) begin
                wr_en[i] = 1'b1;
                accepted = accepted + CW'(1);
            end
        end
    end

    assign count_d  = count_q + accepted - CW'(pop_ok);
    assign wr_ptr_d = wr_ptr_q + accepted[PW-1:0];
    assign rd_ptr_d = rd_ptr_q + PW'(pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_PUSH; i++) begin
                if (wr_en[i]) mem_q[wr_idx[i]] <= entries[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // When empty, the slot just behind the read pointer is the last entry handed out.
    assign head_idx   = (count_q == '0) ? (rd_ptr_q - PW'(1)) : rd_ptr_q;
    assign head       = mem_q[head_idx];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/rca_grid_lsq.sv
// Grid-row request collector: queues qualified row requests and issues them to the shared LSU under lock.
module rca_grid_lsq #(
    parameter  int GRID_NUM_ROWS = rca_config::GRID_NUM_ROWS,
    parameter  int FIFO_DEPTH    = 8,
    parameter  int XLEN          = 32,
    localparam int CW            = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [XLEN-1:0]            grid_addr [GRID_NUM_ROWS],
    input  logic [XLEN-1:0]            grid_data [GRID_NUM_ROWS],
    input  logic [XLEN-1:0]            grid_fn3  [GRID_NUM_ROWS],
    input  logic [GRID_NUM_ROWS-1:0]   grid_load,
    input  logic [GRID_NUM_ROWS-1:0]   grid_store,
    input  logic [GRID_NUM_ROWS-1:0]   grid_new_request,
    output logic                       fifo_full,
    output logic [XLEN-1:0]            lsu_rs1,
    output logic [XLEN-1:0]            lsu_rs2,
    output logic [2:0]                 lsu_fn3,
    output logic                       lsu_load,
    output logic                       lsu_store,
    output logic                       rca_lsu_lock,
    input  logic                       lsu_ready,
    output rca_config::rca_lsq_state_t dbg_state,
    output logic [CW-1:0]              dbg_count
);

    import rca_config::*;

    rca_lsq_state_t     state_q, state_d;
    logic               full_q, full_d;
    logic [GRID_NUM_ROWS-1:0] qual;
    rca_lsq_entry_t     entries [GRID_NUM_ROWS];
    rca_lsq_entry_t     head;
    logic [CW-1:0]      count, count_next;
    logic               any_push, head_vld, pop;
    logic [XLEN-4:0]    unused_fn3_bits;

    always_comb begin
        unused_fn3_bits = '0;
        for (int r = 0; r < GRID_NUM_ROWS; r++) begin
            qual[r]    = grid_new_request[r] && (grid_load[r] ^ grid_store[r]);
            entries[r] = '{addr: grid_addr[r], data: grid_data[r],
                           fn3: grid_fn3[r][2:0], is_store: grid_store[r]};
            unused_fn3_bits = unused_fn3_bits ^ grid_fn3[r][XLEN-1:3];
        end
    end

    assign any_push = |qual;
    assign pop      = (lsu_load | lsu_store) && lsu_ready;

    rca_multi_push_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .NUM_PUSH (GRID_NUM_ROWS)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (qual),
        .entries    (entries),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .count_next (count_next)
    );

    // Leave room for a worst-case push cycle after fifo_full is seen low.
    assign full_d = (CW'(FIFO_DEPTH) - count_next) < CW'(GRID_NUM_ROWS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_push) state_d = ACTIVE;
            ACTIVE:  if ((count_next == '0) && !any_push) state_d = RELEASE;
            RELEASE: state_d = any_push ? ACTIVE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rca_lsu_lock = (state_q != IDLE);
        head_vld     = rca_lsu_lock && (count != '0);
        lsu_load     = head_vld && !head.is_store;
        lsu_store    = head_vld && head.is_store;
    end

    assign lsu_rs1   = head.addr;
    assign lsu_rs2   = head.data;
    assign lsu_fn3   = head.fn3;
    assign fifo_full = full_q;
    assign dbg_state = state_q;
    assign dbg_count = count;

    always @(posedge clk) begin
        if (rst) assert (!(full_q && any_push)) else $error("grid pushed while fifo_full");
    end

endmodule

// File: tb/tb_rca_grid_lsq.sv
// Directed and random stimulus for rca_grid_lsq, checked against a queue-based reference model.
module tb_rca_grid_lsq;

    import rca_config::*;

    localparam int ROWS  = 4;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       grid_addr [ROWS];
    logic [31:0]       grid_data [ROWS];
    logic [31:0]       grid_fn3  [ROWS];
    logic [ROWS-1:0]   grid_load, grid_store, grid_new_request;
    logic              fifo_full;
    logic [31:0]       lsu_rs1, lsu_rs2;
    logic [2:0]        lsu_fn3;
    logic              lsu_load, lsu_store, rca_lsu_lock;
    logic              lsu_ready;
    rca_lsq_state_t    dbg_state;
    logic [3:0]        dbg_count;

    rca_grid_lsq #(.GRID_NUM_ROWS(ROWS), .FIFO_DEPTH(DEPTH), .XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .grid_addr        (grid_addr),
        .grid_data        (grid_data),
        .grid_fn3         (grid_fn3),
        .grid_load        (grid_load),
        .grid_store       (grid_store),
        .grid_new_request (grid_new_request),
        .fifo_full        (fifo_full),
        .lsu_rs1          (lsu_rs1),
        .lsu_rs2          (lsu_rs2),
        .lsu_fn3          (lsu_fn3),
        .lsu_load         (lsu_load),
        .lsu_store        (lsu_store),
        .rca_lsu_lock     (rca_lsu_lock),
        .lsu_ready        (lsu_ready),
        .dbg_state        (dbg_state),
        .dbg_count        (dbg_count)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model: queued entries in order, LSU ownership, and the full flag
    rca_lsq_entry_t exp_q[$];
    rca_lsq_entry_t last_head;
    bit             busy_m, lock_m, full_m;
    int             n_cmp = 0;
    int             n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rows();
        for (int r = 0; r < ROWS; r++) begin
            grid_addr[r] = '0;
            grid_data[r] = '0;
            grid_fn3[r]  = '0;
        end
        grid_load        = '0;
        grid_store       = '0;
        grid_new_request = '0;
    endtask

    task automatic set_row(input int r, input bit ld, input bit st, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] fn3);
        grid_new_request[r] = 1'b1;
        grid_load[r]        = ld;
        grid_store[r]       = st;
        grid_addr[r]        = addr;
        grid_data[r]        = data;
        grid_fn3[r]         = fn3;
    endtask

    // Called just after a falling edge with inputs driven: check outputs, advance model over the rising edge.
    task automatic step(input string tag);
        rca_lsq_entry_t head_e;
        bit             vld, pushed, nxt_busy;
        #1;
        head_e = (exp_q.size() > 0) ? exp_q[0] : last_head;
        vld    = (exp_q.size() > 0) && lock_m;
        chk({tag, ".lock"},  rca_lsu_lock, lock_m);
        chk({tag, ".load"},  lsu_load, vld && !head_e.is_store);
        chk({tag, ".store"}, lsu_store, vld && head_e.is_store);
        chk({tag, ".full"},  fifo_full, full_m);
        chk({tag, ".count"}, dbg_count, exp_q.size());
        chk({tag, ".rs1"},   lsu_rs1, head_e.addr);
        chk({tag, ".rs2"},   lsu_rs2, head_e.data);
        chk({tag, ".fn3"},   lsu_fn3, head_e.fn3);
        if (vld && lsu_ready) last_head = exp_q.pop_front();
        pushed = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (grid_new_request[r] && (grid_load[r] != grid_store[r])) begin
                exp_q.push_back('{addr: grid_addr[r], data: grid_data[r],
                                  fn3: grid_fn3[r][2:0], is_store: grid_store[r]});
                pushed = 1'b1;
            end
        end
        // Ownership continues while work remains; the lock trails ownership by one cycle.
        nxt_busy = pushed || (busy_m && (exp_q.size() != 0));
        lock_m   = nxt_busy || busy_m;
        busy_m   = nxt_busy;
        full_m   = (DEPTH - exp_q.size()) < ROWS;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b0;
        clear_rows();
        lsu_ready = 1'b0;
        #1;
        chk({tag, ".lock"},  rca_lsu_lock, 1'b0);
        chk({tag, ".load"},  lsu_load, 1'b0);
        chk({tag, ".store"}, lsu_store, 1'b0);
        chk({tag, ".full"},  fifo_full, 1'b0);
        chk({tag, ".count"}, dbg_count, 0);
        chk({tag, ".rs1"},   lsu_rs1, 0);
        chk({tag, ".rs2"},   lsu_rs2, 0);
        chk({tag, ".fn3"},   lsu_fn3, 0);
        exp_q.delete();
        last_head = '0;
        busy_m    = 1'b0;
        lock_m    = 1'b0;
        full_m    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        apply_reset("reset");

        // Two loads in one cycle, drained back to back, then lock release
        lsu_ready = 1'b1;
        set_row(0, 1, 0, 32'h100, 32'h0, 32'h2);
        set_row(2, 1, 0, 32'h200, 32'h0, 32'h4);
        step("two_loads");
        clear_rows();
        for (int i = 0; i < 4; i++) step("two_loads_drain");

        // Store held while the LSU stalls
        lsu_ready = 1'b0;
        set_row(1, 0, 1, 32'h40, 32'hDEADBEEF, 32'hFFFF_FFF2);
        step("store");
        clear_rows();
        for (int i = 0; i < 5; i++) step("store_stall");
        lsu_ready = 1'b1;
        for (int i = 0; i < 3; i++) step("store_pop");

        // Fill to capacity with full-width pushes, then drain
        lsu_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < ROWS; r++) set_row(r, 1, 0, $urandom, $urandom, $urandom);
            step("fill");
        end
        clear_rows();
        step("fill_hold");
        lsu_ready = 1'b1;
        for (int i = 0; i < 11; i++) step("fill_drain");

        // Malformed row request dropped, valid one kept
        lsu_ready = 1'b0;
        set_row(3, 1, 1, 32'h300, 32'h1, 32'h1);
        set_row(0, 1, 0, 32'h10, 32'h2, 32'h5);
        set_row(1, 0, 0, 32'h20, 32'h3, 32'h6);
        step("qualify");
        clear_rows();
        step("qualify_count");
        lsu_ready = 1'b1;
        for (int i = 0; i < 3; i++) step("qualify_drain");

        // One in, one out, across a pointer wrap
        lsu_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            clear_rows();
            set_row(0, $urandom_range(0, 1), 0, $urandom, $urandom, $urandom);
            grid_store[0] = ~grid_load[0];
            step("stream");
        end
        clear_rows();
        for (int i = 0; i < 3; i++) step("stream_drain");

        // Reset while owning the LSU with queued entries
        lsu_ready = 1'b0;
        for (int r = 0; r < 3; r++) set_row(r, 0, 1, $urandom, $urandom, $urandom);
        step("pre_reset");
        clear_rows();
        step("pre_reset_hold");
        apply_reset("mid_reset");
        lsu_ready = 1'b1;
        for (int i = 0; i < 4; i++) step("post_reset");

        // Random traffic, respecting fifo_full as predicted by the model
        for (int i = 0; i < 300; i++) begin
            clear_rows();
            if (!full_m) begin
                for (int r = 0; r < ROWS; r++) begin
                    if ($urandom_range(0, 9) < 3) begin
                        set_row(r, $urandom_range(0, 1), $urandom_range(0, 1),
                                $urandom, $urandom, $urandom);
                    end
                end
            end
            lsu_ready = ($urandom_range(0, 2) != 0);
            step("random");
        end
        clear_rows();
        lsu_ready = 1'b1;
        for (int i = 0; i < 12; i++) step("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
